// File: rtl/click_classifier.sv
// click_classifier: groups debounced press pulses into counted click events over valid/ready.
// Define CLICK_CLASSIFIER_QUEUE_EN to hold one press arriving during REPORT as the start of the next burst.
module click_classifier #(
  parameter int WINDOW     = 12500000,
  parameter int MAX_CLICKS = 3,
  parameter int CW         = 24,
  parameter int NW         = 2
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_press,
  output logic          o_click_valid,
  input  logic          i_click_ready,
  output logic [NW-1:0] o_click_count,
  output logic          o_dropped
);
  localparam logic [1:0]    IDLE   = 2'd0;
  localparam logic [1:0]    COUNT  = 2'd1;
  localparam logic [1:0]    REPORT = 2'd2;
  localparam logic [NW-1:0] ONE    = NW'(1);
  localparam logic [NW-1:0] MAX_C  = NW'(MAX_CLICKS);
  localparam logic [CW-1:0] TMO    = CW'(WINDOW - 1);
  localparam logic [1:0]    START  = (MAX_CLICKS == 1) ? REPORT : COUNT;
  logic [1:0]    r_state, w_state_nxt;
  logic [NW-1:0] r_count, w_count_nxt, w_count_inc;
  logic [CW-1:0] r_timer, w_timer_nxt;
  logic          r_dropped, w_dropped_nxt;
  logic          w_hs;
`ifdef CLICK_CLASSIFIER_QUEUE_EN
  logic          r_pending, w_pending_nxt;
`endif
  assign w_hs          = (r_state == REPORT) && i_click_ready;
  assign w_count_inc   = r_count + ONE;
  assign o_click_valid = (r_state == REPORT);
  assign o_click_count = o_click_valid ? r_count : '0;
  assign o_dropped     = r_dropped;
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_timer_nxt   = r_timer;
    w_dropped_nxt = 1'b0;
`ifdef CLICK_CLASSIFIER_QUEUE_EN
    w_pending_nxt = r_pending;
`endif
    case (r_state)
      IDLE: begin
        w_state_nxt = i_press ? START : IDLE;
        w_count_nxt = i_press ? ONE : '0;
        w_timer_nxt = '0;
      end
      COUNT: begin
        // A press on the timeout edge wins and keeps the burst open.
        w_state_nxt = (i_press ? (w_count_inc == MAX_C) : (r_timer == TMO)) ? REPORT : COUNT;
        w_count_nxt = i_press ? w_count_inc : r_count;
        w_timer_nxt = i_press ? '0 : r_timer + 1'b1;
      end
      REPORT: begin
`ifdef CLICK_CLASSIFIER_QUEUE_EN
        w_dropped_nxt = i_press && r_pending;
        w_pending_nxt = w_hs ? 1'b0 : (r_pending || i_press);
        w_state_nxt   = w_hs ? ((r_pending || i_press) ? START : IDLE) : REPORT;
        w_count_nxt   = w_hs ? ((r_pending || i_press) ? ONE : '0) : r_count;
        w_timer_nxt   = '0;
`else
        w_dropped_nxt = i_press;
        w_state_nxt   = w_hs ? IDLE : REPORT;
        w_count_nxt   = w_hs ? '0 : r_count;
        w_timer_nxt   = '0;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
        w_timer_nxt = '0;
      end
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_timer   <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_timer   <= w_timer_nxt;
      r_dropped <= w_dropped_nxt;
    end
  end
`ifdef CLICK_CLASSIFIER_QUEUE_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_pending <= 1'b0;
    else            r_pending <= w_pending_nxt;
  end
`endif
endmodule
